// File: rtl/ball_draw_pkg.sv
// Shared types, colour constants and the 32x32 ball shape ROM for multi_ball_draw.
package ball_draw_pkg;

  typedef enum logic [1:0] {
    TRANSPARENT = 2'd0,
    BODY        = 2'd1,
    BLACK       = 2'd2,
    WHITE       = 2'd3
  } ball_code_t;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    SINKING = 2'd1,
    GONE    = 2'd2
  } ball_state_t;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
  localparam logic [7:0] BLACK_RGB            = 8'h00;
  localparam logic [7:0] WHITE_RGB            = 8'hFE;

  localparam int ROM_SIZE = 32;

  // Code for (y,x) lives at bits [2*(32*y+x) +: 2].
  typedef logic [2*ROM_SIZE*ROM_SIZE-1:0] shape_rom_t;

  // Disc of radius 16 filled with BODY, plus a number badge centred 8 rows
  // above the middle: WHITE disc of radius 3 inside a BLACK ring out to radius 5.
  // Distances are kept in doubled coordinates so pixel centres stay integral.
  function automatic shape_rom_t build_shape_rom();
    shape_rom_t rom;
    int         dx, dy, by, r2, b2;
    ball_code_t c;
    rom = '0;
    for (int y = 0; y < ROM_SIZE; y++) begin
      for (int x = 0; x < ROM_SIZE; x++) begin
        dx = 2 * x - 31;
        dy = 2 * y - 31;
        by = 2 * y - 15;
        r2 = dx * dx + dy * dy;
        b2 = dx * dx + by * by;
        if (r2 >= 1024)    c = TRANSPARENT;
        else if (b2 < 36)  c = WHITE;
        else if (b2 < 100) c = BLACK;
        else               c = BODY;
        rom[2*(y*ROM_SIZE+x) +: 2] = c;
      end
    end
    return rom;
  endfunction

  localparam shape_rom_t SHAPE_ROM = build_shape_rom();

  function automatic ball_code_t shape_lookup(input logic [4:0] y, input logic [4:0] x);
    logic [10:0] idx;
    idx = {y, x, 1'b0};
    return ball_code_t'(SHAPE_ROM[idx +: 2]);
  endfunction

endpackage

// File: rtl/multi_ball_draw_channel.sv
// One ball channel: sink/respawn FSM with inset and frame counter, and the
// two-stage hit / shape-lookup pipeline producing a registered opaque flag and colour.
module ball_channel
  import ball_draw_pkg::*;
#(
  parameter int BALL_SIZE       = 32,
  parameter int SHRINK_STEP     = 2,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_of_frame,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic        show,
  input  logic [7:0]  color,
  input  logic        sink_start,
  input  logic        respawn,
  output logic        opaque,
  output logic [7:0]  rgb,
  output logic        sunk
);

  localparam int OW = $clog2(BALL_SIZE);
  localparam int IW = OW + 2;
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  ball_state_t   state_q, state_d;
  logic [IW-1:0] inset_q, inset_d, step_inset;
  logic [FW-1:0] frame_q, frame_d;

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    inset_d    = inset_q;
    frame_d    = frame_q;
    step_inset = inset_q + IW'(SHRINK_STEP);
    if (respawn) begin
      state_d = VISIBLE;
      inset_d = '0;
      frame_d = '0;
    end else begin
      case (state_q)
        VISIBLE: if (sink_start) begin
          state_d = SINKING;
          inset_d = '0;
          frame_d = '0;
        end
        SINKING: if (start_of_frame) begin
          if (frame_q == FW'(FRAMES_PER_STEP - 1)) begin
            frame_d = '0;
            inset_d = step_inset;
            if (step_inset >= IW'(BALL_SIZE / 2)) state_d = GONE;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= VISIBLE;
      inset_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      inset_q <= inset_d;
      frame_q <= frame_d;
    end
  end

  assign sunk = (state_q == GONE);

  // Stage 1: box test in 12 bits so pos+BALL_SIZE cannot wrap past column 2047.
  logic [11:0]   px12, py12, x12, y12;
  logic [10:0]   diff_x, diff_y;
  logic          hit_d, hit_q;
  logic [OW-1:0] off_x_q, off_y_q;

  assign px12   = {1'b0, pixel_x};
  assign py12   = {1'b0, pixel_y};
  assign x12    = {1'b0, pos_x};
  assign y12    = {1'b0, pos_y};
  assign diff_x = pixel_x - pos_x;
  assign diff_y = pixel_y - pos_y;
  assign hit_d  = (px12 >= x12) && (px12 < x12 + 12'(BALL_SIZE)) &&
                  (py12 >= y12) && (py12 < y12 + 12'(BALL_SIZE));

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q   <= 1'b0;
      off_x_q <= '0;
      off_y_q <= '0;
    end else begin
      hit_q   <= hit_d;
      off_x_q <= diff_x[OW-1:0];
      off_y_q <= diff_y[OW-1:0];
    end
  end

  // Stage 2: shape lookup scaled onto the 32x32 ROM, inset window, colour select.
  logic [4:0]    rom_x, rom_y;
  ball_code_t    code;
  logic [IW-1:0] ox, oy, hi_lim;
  logic          in_window, opaque_d;
  logic [7:0]    rgb_d;

  assign rom_x     = 5'((32'(off_x_q) * ROM_SIZE) / BALL_SIZE);
  assign rom_y     = 5'((32'(off_y_q) * ROM_SIZE) / BALL_SIZE);
  assign code      = shape_lookup(rom_y, rom_x);
  assign ox        = IW'(off_x_q);
  assign oy        = IW'(off_y_q);
  assign hi_lim    = IW'(BALL_SIZE - 1) - inset_q;
  assign in_window = (ox >= inset_q) && (ox <= hi_lim) && (oy >= inset_q) && (oy <= hi_lim);
  assign opaque_d  = hit_q && show && (state_q != GONE) && (code != TRANSPARENT) && in_window;

  always_comb begin
    rgb_d = TRANSPARENT_ENCODING;
    case (code)
      BODY:    rgb_d = color;
      BLACK:   rgb_d = BLACK_RGB;
      WHITE:   rgb_d = WHITE_RGB;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opaque <= 1'b0;
      rgb    <= TRANSPARENT_ENCODING;
    end else begin
      opaque <= opaque_d;
      rgb    <= rgb_d;
    end
  end

endmodule

// File: rtl/multi_ball_draw.sv
// Multi-ball sprite drawer: one ball_channel per ball, lowest-index priority merge.
// Optional BALL_OVERLAP_EN adds overlapPulse / overlapMask outputs.
module multi_ball_draw
  import ball_draw_pkg::*;
#(
  parameter int NUM_BALLS       = 4,
  parameter int BALL_SIZE       = 32,
  parameter int SHRINK_STEP     = 2,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic [10:0]             pixelX,
  input  logic [10:0]             pixelY,
  input  logic [NUM_BALLS*11-1:0] ballTopLeftPosX,
  input  logic [NUM_BALLS*11-1:0] ballTopLeftPosY,
  input  logic [NUM_BALLS-1:0]    ballShow,
  input  logic [NUM_BALLS*8-1:0]  ballColor,
  input  logic [NUM_BALLS-1:0]    sinkStart,
  input  logic [NUM_BALLS-1:0]    respawn,
  output logic                    drawingRequestBall,
  output logic [7:0]              RGBoutBall,
  output logic [2:0]              drawnBallId,
  output logic [NUM_BALLS-1:0]    ballSunk
`ifdef BALL_OVERLAP_EN
  ,
  output logic                    overlapPulse,
  output logic [NUM_BALLS-1:0]    overlapMask
`endif
);

  logic [NUM_BALLS-1:0] ball_opaque;
  logic [7:0]           ball_rgb [NUM_BALLS];
  logic [2:0]           id_q;

  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ch
    ball_channel #(
      .BALL_SIZE      (BALL_SIZE),
      .SHRINK_STEP    (SHRINK_STEP),
      .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .start_of_frame(startOfFrame),
      .pixel_x       (pixelX),
      .pixel_y       (pixelY),
      .pos_x         (ballTopLeftPosX[11*i +: 11]),
      .pos_y         (ballTopLeftPosY[11*i +: 11]),
      .show          (ballShow[i]),
      .color         (ballColor[8*i +: 8]),
      .sink_start    (sinkStart[i]),
      .respawn       (respawn[i]),
      .opaque        (ball_opaque[i]),
      .rgb           (ball_rgb[i]),
      .sunk          (ballSunk[i])
    );
  end

  // Scan from the top index down so the lowest opaque index is the last writer.
  always_comb begin
    drawingRequestBall = 1'b0;
    RGBoutBall         = TRANSPARENT_ENCODING;
    drawnBallId        = id_q;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (ball_opaque[i]) begin
        drawingRequestBall = 1'b1;
        RGBoutBall         = ball_rgb[i];
        drawnBallId        = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) id_q <= '0;
    else       id_q <= drawnBallId;
  end

`ifdef BALL_OVERLAP_EN
  logic                 multi_hit;
  logic [NUM_BALLS-1:0] new_mask;

  assign multi_hit    = ($countones(ball_opaque) >= 2);
  assign new_mask     = multi_hit ? ball_opaque : '0;
  assign overlapPulse = multi_hit;

  // Frame start clears the mask but keeps an overlap seen on that same cycle.
  always_ff @(posedge clk) begin
    if (reset)             overlapMask <= '0;
    else if (startOfFrame) overlapMask <= new_mask;
    else                   overlapMask <= overlapMask | new_mask;
  end
`endif

endmodule

// File: tb/tb_multi_ball_draw.sv
// Directed self-checking bench for multi_ball_draw (default parameters).
// Build with BALL_OVERLAP_EN defined to also exercise the overlap outputs.
module tb_multi_ball_draw;

  localparam int NB = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             startOfFrame;
  logic [10:0]      pixelX, pixelY;
  logic [NB*11-1:0] ballTopLeftPosX, ballTopLeftPosY;
  logic [NB-1:0]    ballShow;
  logic [NB*8-1:0]  ballColor;
  logic [NB-1:0]    sinkStart, respawn;
  logic             drawingRequestBall;
  logic [7:0]       RGBoutBall;
  logic [2:0]       drawnBallId;
  logic [NB-1:0]    ballSunk;
`ifdef BALL_OVERLAP_EN
  logic             overlapPulse;
  logic [NB-1:0]    overlapMask;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_ball_draw #(.NUM_BALLS(NB)) dut (
    .clk               (clk),
    .reset             (reset),
    .startOfFrame      (startOfFrame),
    .pixelX            (pixelX),
    .pixelY            (pixelY),
    .ballTopLeftPosX   (ballTopLeftPosX),
    .ballTopLeftPosY   (ballTopLeftPosY),
    .ballShow          (ballShow),
    .ballColor         (ballColor),
    .sinkStart         (sinkStart),
    .respawn           (respawn),
    .drawingRequestBall(drawingRequestBall),
    .RGBoutBall        (RGBoutBall),
    .drawnBallId       (drawnBallId),
    .ballSunk          (ballSunk)
`ifdef BALL_OVERLAP_EN
    ,
    .overlapPulse      (overlapPulse),
    .overlapMask       (overlapMask)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ball(input int i, input int x, input int y, input logic [7:0] c, input logic s);
    ballTopLeftPosX[11*i +: 11] = 11'(x);
    ballTopLeftPosY[11*i +: 11] = 11'(y);
    ballColor[8*i +: 8]         = c;
    ballShow[i]                 = s;
  endtask

  // Present a pixel and sample once its result has crossed both pipeline stages.
  task automatic scan(input int x, input int y);
    @(negedge clk);
    pixelX = 11'(x);
    pixelY = 11'(y);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
    end
  endtask

  task automatic pulse(input logic [NB-1:0] sk, input logic [NB-1:0] rs);
    @(negedge clk);
    sinkStart = sk;
    respawn   = rs;
    @(negedge clk);
    sinkStart = '0;
    respawn   = '0;
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
    ballTopLeftPosX = '0; ballTopLeftPosY = '0; ballShow = '0; ballColor = '0;
    sinkStart = '0; respawn = '0;
    set_ball(0, 100,  50, 8'hE0, 1'b1);
    set_ball(1, 400, 300, 8'h1C, 1'b1);
    set_ball(2, 200, 200, 8'h03, 1'b0);
    set_ball(3, 600, 400, 8'h92, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",  32'(drawingRequestBall), 32'd0);
    check("rst_rgb",  32'(RGBoutBall),         32'hFF);
    check("rst_id",   32'(drawnBallId),        32'd0);
    check("rst_sunk", 32'(ballSunk),           32'd0);
    @(negedge clk) reset = 1'b0;

    // Ball 0 body, corner, badge white and badge black ring.
    scan(116, 66);
    check("body_req", 32'(drawingRequestBall), 32'd1);
    check("body_rgb", 32'(RGBoutBall),         32'hE0);
    check("body_id",  32'(drawnBallId),        32'd0);
    scan(100, 50);
    check("corner_req", 32'(drawingRequestBall), 32'd0);
    check("corner_rgb", 32'(RGBoutBall),         32'hFF);
    scan(116, 58);
    check("white_rgb", 32'(RGBoutBall), 32'hFE);
    scan(116, 61);
    check("black_req", 32'(drawingRequestBall), 32'd1);
    check("black_rgb", 32'(RGBoutBall),         32'h00);

    // Priority between balls 0 and 2 on the same spot; id holds on empty pixel.
    set_ball(0, 200, 200, 8'hE0, 1'b1);
    set_ball(2, 200, 200, 8'h03, 1'b1);
    scan(216, 216);
    check("prio_id0",  32'(drawnBallId), 32'd0);
    check("prio_rgb0", 32'(RGBoutBall),  32'hE0);
    ballShow[0] = 1'b0;
    scan(216, 216);
    check("prio_id2",  32'(drawnBallId), 32'd2);
    check("prio_rgb2", 32'(RGBoutBall),  32'h03);
    scan(50, 50);
    check("empty_req",  32'(drawingRequestBall), 32'd0);
    check("empty_hold", 32'(drawnBallId),        32'd2);
    set_ball(0, 100, 50, 8'hE0, 1'b1);

    // Near the right edge of the 11-bit range: no wrap-around hit.
    set_ball(2, 2030, 50, 8'h03, 1'b1);
    scan(5, 66);
    check("wrap_nohit", 32'(drawingRequestBall), 32'd0);
    scan(2040, 66);
    check("edge_hit", 32'(drawingRequestBall), 32'd1);
    check("edge_id",  32'(drawnBallId),        32'd2);
    ballShow[2] = 1'b0;

    // Sink ball 1.
    scan(401, 316);
    check("pre_sink", 32'(drawingRequestBall), 32'd1);
    pulse(4'b0010, 4'b0000);
    frames(3);
    scan(401, 316);
    check("f3_inset0", 32'(drawingRequestBall), 32'd1);
    frames(1);
    scan(401, 316);
    check("f4_off1", 32'(drawingRequestBall), 32'd0);
    scan(402, 316);
    check("f4_off2_req", 32'(drawingRequestBall), 32'd1);
    check("f4_off2_rgb", 32'(RGBoutBall),         32'h1C);
    frames(27);
    scan(416, 316);
    check("f31_sunk", 32'(ballSunk),           32'd0);
    check("f31_draw", 32'(drawingRequestBall), 32'd1);
    frames(1);
    scan(416, 316);
    check("f32_sunk", 32'(ballSunk),           32'b0010);
    check("f32_draw", 32'(drawingRequestBall), 32'd0);
    pulse(4'b0010, 4'b0000);
    check("gone_ign", 32'(ballSunk), 32'b0010);

    // Respawn, then respawn beating a simultaneous sink.
    pulse(4'b0000, 4'b0010);
    scan(401, 316);
    check("resp_sunk", 32'(ballSunk),           32'd0);
    check("resp_draw", 32'(drawingRequestBall), 32'd1);
    pulse(4'b0010, 4'b0010);
    frames(4);
    scan(401, 316);
    check("both_draw", 32'(drawingRequestBall), 32'd1);
    check("both_sunk", 32'(ballSunk),           32'd0);

    // Reset mid-frame clears outputs on the next edge.
    scan(416, 316);
    check("pre_rst_id", 32'(drawnBallId), 32'd1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_req", 32'(drawingRequestBall), 32'd0);
    check("mid_rst_rgb", 32'(RGBoutBall),         32'hFF);
    check("mid_rst_id",  32'(drawnBallId),        32'd0);
    @(negedge clk) reset = 1'b0;

`ifdef BALL_OVERLAP_EN
    set_ball(0, 100, 50, 8'hE0, 1'b0);
    set_ball(3, 400, 300, 8'h92, 1'b1);
    scan(416, 316);
    check("ov_pulse", 32'(overlapPulse), 32'd1);
    check("ov_id",    32'(drawnBallId),  32'd1);
    @(posedge clk);
    #1;
    check("ov_mask", 32'(overlapMask), 32'b1010);
    scan(50, 50);
    check("ov_pulse0", 32'(overlapPulse), 32'd0);
    check("ov_sticky", 32'(overlapMask),  32'b1010);
    frames(1);
    check("ov_clear", 32'(overlapMask), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
